// File: rtl/ad7991_i2c_responder_pkg.sv
// Shared definitions for the AD7991 I2C responder: state encoding, reset values,
// conversion-word layout and channel-selection helpers.
package ad7991_i2c_responder_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h28;
  localparam logic [7:0] CFG_RESET        = 8'hF0;
  localparam int         CHID_MSB         = 13;
  localparam int         CHID_LSB         = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  // An empty selection behaves as CH0 only.
  function automatic logic [3:0] chan_sel(input logic [7:0] cfg_byte);
    chan_sel = (cfg_byte[7:4] == 4'b0000) ? 4'b0001 : cfg_byte[7:4];
  endfunction

  // Next selected channel after ptr, wrapping; next_chan(sel, 3) yields the lowest one.
  function automatic logic [1:0] next_chan(input logic [3:0] sel, input logic [1:0] ptr);
    logic [1:0] c;
    next_chan = ptr;
    for (int i = 3; i >= 1; i--) begin
      c = ptr + 2'(i);
      if (sel[c]) next_chan = c;
    end
  endfunction

  function automatic logic [15:0] make_word(input logic [1:0] ch, input logic [11:0] val);
    logic [15:0] w;
    w                    = '0;
    w[CHID_MSB:CHID_LSB] = ch;
    w[11:0]              = val;
    make_word            = w;
  endfunction

endpackage

// File: rtl/ad7991_i2c_responder_i2c_line_filter.sv
// SCL/SDA input conditioning: 2-FF synchroniser, stable-run glitch filter, and
// single-cycle edge / START / STOP strobes derived from the filtered lines.
module i2c_line_filter #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0]             scl_sync_q, sda_sync_q;
  logic [FILT_CYCLES-1:0] scl_hist_q, sda_hist_q;
  logic                   scl_f_q, sda_f_q;
  logic                   scl_f_d, sda_f_d;

  // A filtered line only changes once the synchronised input held for FILT_CYCLES clocks.
  always_comb begin
    scl_f_d = scl_f_q;
    sda_f_d = sda_f_q;
    if (&scl_hist_q)      scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    if (&sda_hist_q)      sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= FILT_CYCLES'({scl_hist_q, scl_sync_q[1]});
      sda_hist_q <= FILT_CYCLES'({sda_hist_q, sda_sync_q[1]});
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
    end
  end

  assign sda_o      = sda_f_q;
  assign scl_rise_o = scl_f_d & ~scl_f_q;
  assign scl_fall_o = ~scl_f_d & scl_f_q;
  assign start_o    = ~sda_f_d & sda_f_q & scl_f_q;
  assign stop_o     = sda_f_d & ~sda_f_q & scl_f_q;

endmodule

// File: rtl/ad7991_i2c_responder.sv
// I2C target emulating an AD7991 4-channel 12-bit ADC: accepts the config-byte
// write and returns 2-byte conversion words for the selected channels round-robin.
module ad7991_i2c_responder
  import ad7991_i2c_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         FILT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AD2_SCL,
  inout  wire         AD2_SDA,
  input  logic [11:0] ch0_value,
  input  logic [11:0] ch1_value,
  input  logic [11:0] ch2_value,
  input  logic [11:0] ch3_value,
  output logic [7:0]  cfg,
  output logic        busy,
  output logic        word_sent
);

  logic        sda_f, scl_rise, scl_fall, start_det, stop_det;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d, cfg_q, cfg_d, tx_byte;
  logic [15:0] word_q, word_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [11:0] ch_val;
  logic        rw_q, rw_d, first_wr_q, first_wr_d, lo_q, lo_d;
  logic        busy_q, busy_d, ws_q, ws_d, sda_low_q, sda_low_d;

  i2c_line_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
    .clk       (clk),
    .rst_n_i   (rst),
    .scl_i     (AD2_SCL),
    .sda_i     (AD2_SDA),
    .sda_o     (sda_f),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  always_comb begin
    case (ptr_q)
      2'd0:    ch_val = ch0_value;
      2'd1:    ch_val = ch1_value;
      2'd2:    ch_val = ch2_value;
      default: ch_val = ch3_value;
    endcase
  end

  assign tx_byte = lo_q ? word_q[7:0] : word_q[15:8];

  // bit_cnt counts 7 down past 0; bit 3 set means all 8 bits of the byte have clocked.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    first_wr_d = first_wr_q;
    lo_d       = lo_q;
    word_d     = word_q;
    ptr_d      = ptr_q;
    cfg_d      = cfg_q;
    busy_d     = busy_q;
    ws_d       = 1'b0;
    sda_low_d  = sda_low_q;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd7;
      busy_d    = 1'b1;
      sda_low_d = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_WR_BYTE: begin
          if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall && bit_cnt_q[3]) begin
            if (state_q == ST_WR_BYTE) begin
              state_d   = ST_WR_ACK;
              sda_low_d = 1'b1;
            end else if (sh_q[7:1] == DEV_ADDR) begin
              state_d   = ST_ADDR_ACK;
              rw_d      = sh_q[0];
              sda_low_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd7;
            lo_d      = 1'b0;
            if (rw_q) begin
              state_d   = ST_RD_BYTE;
              word_d    = make_word(ptr_q, ch_val);
              sda_low_d = ~word_d[15];
            end else begin
              state_d    = ST_WR_BYTE;
              first_wr_d = 1'b1;
              sda_low_d  = 1'b0;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (first_wr_q) begin
              cfg_d      = sh_q;
              ptr_d      = next_chan(chan_sel(sh_q), 2'd3);
              first_wr_d = 1'b0;
            end
            state_d   = ST_WR_BYTE;
            bit_cnt_d = 4'd7;
            sda_low_d = 1'b0;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q[3]) begin
              state_d   = ST_RD_ACK;
              sda_low_d = 1'b0;
            end else begin
              sda_low_d = ~tx_byte[bit_cnt_q[2:0]];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (lo_q) begin
              ws_d  = 1'b1;
              ptr_d = next_chan(chan_sel(cfg_q), ptr_q);
            end
            if (sda_f) state_d = ST_IGNORE;
          end else if (scl_fall) begin
            state_d   = ST_RD_BYTE;
            bit_cnt_d = 4'd7;
            if (lo_q) begin
              lo_d      = 1'b0;
              word_d    = make_word(ptr_q, ch_val);
              sda_low_d = ~word_d[15];
            end else begin
              lo_d      = 1'b1;
              sda_low_d = ~word_q[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd7;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      first_wr_q <= 1'b0;
      lo_q       <= 1'b0;
      word_q     <= '0;
      ptr_q      <= '0;
      cfg_q      <= CFG_RESET;
      busy_q     <= 1'b0;
      ws_q       <= 1'b0;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      first_wr_q <= first_wr_d;
      lo_q       <= lo_d;
      word_q     <= word_d;
      ptr_q      <= ptr_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      ws_q       <= ws_d;
      sda_low_q  <= sda_low_d;
    end
  end

  assign AD2_SDA   = sda_low_q ? 1'b0 : 1'bz;
  assign cfg       = cfg_q;
  assign busy      = busy_q;
  assign word_sent = ws_q;

endmodule

// File: tb/tb_ad7991_i2c_responder.sv
// Bench for the AD7991 responder: 400 kHz I2C controller BFM on a pulled-up bus,
// with a scoreboard queue of expected ACK bits and read bytes.
module tb_ad7991_i2c_responder;

  localparam time Q = 625ns;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        tb_sda_low = 1'b0;
  logic [11:0] ch0 = 12'hABC, ch1 = 12'h123, ch2 = 12'h555, ch3 = 12'hFFF;
  logic [7:0]  cfg;
  logic        busy, word_sent;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  always #5ns clk = ~clk;

  ad7991_i2c_responder dut (
    .clk      (clk),
    .rst      (rst_n),
    .AD2_SCL  (scl),
    .AD2_SDA  (sda_bus),
    .ch0_value(ch0),
    .ch1_value(ch1),
    .ch2_value(ch2),
    .ch3_value(ch3),
    .cfg      (cfg),
    .busy     (busy),
    .word_sent(word_sent)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ws_cnt = 0;
  int    low_cnt = 0;

  always @(negedge clk) begin
    if (word_sent === 1'b1) ws_cnt++;
    if (sda_bus === 1'b0 && !tb_sda_low) low_cnt++;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, expv);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: compares every observed bus response against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        item_t o;
        item_t e;
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s: got %02h with no expected value queued", o.name, o.val);
        end else begin
          e = exp_q.pop_front();
          check8(e.name, o.val, e.val);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run exceeded 5 ms, got no finish expected finish");
    $fatal(1);
  end

  task automatic bit_out(input logic b);
    tb_sda_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic bit_in(output logic b);
    tb_sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    tb_sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q tb_sda_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    tb_sda_low = 1'b1;
    #Q scl = 1'b1;
    #Q tb_sda_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input string nm, input logic exp_nack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    exp_q.push_back('{name: nm, val: {7'b0, exp_nack}});
    bit_in(a);
    obs_q.push_back('{name: nm, val: {7'b0, a}});
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] expv, input string nm);
    logic [7:0] d;
    logic       b;
    exp_q.push_back('{name: nm, val: expv});
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    obs_q.push_back('{name: nm, val: d});
    bit_out(nack);
  endtask

  initial begin
    int ws0;
    int low0;
    #100ns;
    check8("rst_cfg", cfg, 8'hF0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_word_sent", word_sent, 1'b0);
    check1("rst_sda_released", sda_bus, 1'b1);
    rst_n = 1'b1;
    #200ns;

    // config write with ch0 only selected
    i2c_start;
    check1("t1_busy_after_start", busy, 1'b1);
    write_byte(8'h50, "t1_addr_ack", 1'b0);
    write_byte(8'h10, "t1_data_ack", 1'b0);
    i2c_stop;
    check8("t1_cfg", cfg, 8'h10);
    check1("t1_busy_after_stop", busy, 1'b0);

    // single-word read of ch0
    ws0 = ws_cnt;
    i2c_start;
    write_byte(8'h51, "t2_addr_ack", 1'b0);
    read_byte(1'b0, 8'h0A, "t2_hi");
    read_byte(1'b1, 8'hBC, "t2_lo");
    i2c_stop;
    check_int("t2_word_sent", ws_cnt - ws0, 1);

    // CH1+CH3 selection; extra write byte must be ACKed and discarded
    i2c_start;
    write_byte(8'h50, "t3_addr_ack", 1'b0);
    write_byte(8'hA0, "t3_cfg_ack", 1'b0);
    write_byte(8'h30, "t3_extra_ack", 1'b0);
    i2c_stop;
    check8("t3_cfg", cfg, 8'hA0);
    ws0 = ws_cnt;
    i2c_start;
    write_byte(8'h51, "t3_rd_addr_ack", 1'b0);
    read_byte(1'b0, 8'h11, "t3_ch1_hi");
    read_byte(1'b0, 8'h23, "t3_ch1_lo");
    read_byte(1'b0, 8'h3F, "t3_ch3_hi");
    read_byte(1'b1, 8'hFF, "t3_ch3_lo");
    i2c_stop;
    check_int("t3_word_sent_4b", ws_cnt - ws0, 2);
    ws0 = ws_cnt;
    i2c_start;
    write_byte(8'h51, "t3_wrap_addr_ack", 1'b0);
    read_byte(1'b0, 8'h11, "t3_wrap_hi");
    read_byte(1'b1, 8'h23, "t3_wrap_lo");
    i2c_stop;
    check_int("t3_word_sent_wrap", ws_cnt - ws0, 1);

    // foreign address: no ACK, bus never pulled low by the target
    low0 = low_cnt;
    i2c_start;
    write_byte(8'h55, "t4_addr_nack", 1'b1);
    check1("t4_busy_mid", busy, 1'b1);
    i2c_stop;
    check_int("t4_target_low_clks", low_cnt - low0, 0);
    check8("t4_cfg_kept", cfg, 8'hA0);
    check1("t4_busy_after_stop", busy, 1'b0);

    // repeated START after a high byte leaves the pointer on ch3
    ws0 = ws_cnt;
    i2c_start;
    write_byte(8'h51, "t5_addr_ack", 1'b0);
    read_byte(1'b1, 8'h3F, "t5_hi_only");
    i2c_start;
    check1("t5_busy_rs", busy, 1'b1);
    write_byte(8'h51, "t5_rs_addr_ack", 1'b0);
    read_byte(1'b0, 8'h3F, "t5_rs_hi");
    read_byte(1'b1, 8'hFF, "t5_rs_lo");
    i2c_stop;
    check_int("t5_word_sent", ws_cnt - ws0, 1);

    // reset while the target drives the first (zero) bit of ch1's high byte
    i2c_start;
    write_byte(8'h51, "t6_addr_ack", 1'b0);
    tb_sda_low = 1'b0;
    #Q;
    check1("t6_target_drives_0", sda_bus, 1'b0);
    rst_n = 1'b0;
    #1ns;
    check1("t6_sda_released", sda_bus, 1'b1);
    @(posedge clk);
    #1ns;
    check1("t6_busy_reset", busy, 1'b0);
    check8("t6_cfg_reset", cfg, 8'hF0);
    #100ns rst_n = 1'b1;
    #200ns;
    i2c_stop;
    ch0 = 12'h456;
    i2c_start;
    write_byte(8'h51, "t6_rd_addr_ack", 1'b0);
    read_byte(1'b0, 8'h04, "t6_ch0_hi");
    ch0 = 12'h999;
    read_byte(1'b1, 8'h56, "t6_ch0_lo_latched");
    i2c_stop;
    check8("t6_cfg_final", cfg, 8'hF0);

    repeat (20) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d unmatched expectations expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
